// File: rtl/pipe_wb_cp0.sv
// rtl/pipe_wb_cp0.sv - write-back stage with CP0 (optional Count/Compare timer under CP0_TIMER_EN)
module pipe_wb_cp0 #(
    parameter logic [31:0] STATUS_RST = 32'h0000_0000,
    parameter logic [4:0]  HALT_CODE  = 5'd9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wb_validto,
    input  logic        bypass_rdc_valid_in,
    input  logic [31:0] wb_result_in,
    input  logic [4:0]  rdc_mem_in,
    input  logic        rf_we_in,
    input  logic        cp0_rd_mux_sel_in,
    input  logic        cp0_we_in,
    input  logic [4:0]  cp0_rdc_in,
    input  logic [31:0] cp0_data_in,
    input  logic        ex_wb_in,
    input  logic [4:0]  ex_code_in,
    input  logic        eret_flush_in,
    input  logic        branch_delay_wb_in,
    input  logic [31:0] pc_in,
    input  logic [7:0]  int_sig_in,
    output logic        wb_allowin,
    output logic [4:0]  rdc_wb,
    output logic [31:0] wb_result,
    output logic        rf_we,
    output logic [31:0] bypass_wb,
    output logic        wb_rdc_valid,
    output logic        ex,
    output logic        flush,
    output logic        hlt,
    output logic        ie,
    output logic        exl,
    output logic [7:0]  int_mask,
    output logic [7:0]  int_sig,
    output logic [31:0] epc_out
);
    logic        wb_valid;
    logic [31:0] wb_result_q, cp0_data_q, pc_q;
    logic [4:0]  rdc_q, cp0_rdc_q, ex_code_q;
    logic        rf_we_q, bypass_rdc_valid_q, cp0_rd_mux_sel_q, cp0_we_q;
    logic        ex_q, eret_q, bd_q;

    logic        cause_bd;
    logic [4:0]  cause_exc;
    logic [31:0] cp0_rdata, status_rd, cause_rd;
    logic        int_pend, take, mtc0_commit, ip7_src;
    logic [4:0]  take_code;

    assign wb_allowin = ~hlt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid           <= 1'b0;
            wb_result_q        <= 32'd0;
            cp0_data_q         <= 32'd0;
            pc_q               <= 32'd0;
            rdc_q              <= 5'd0;
            cp0_rdc_q          <= 5'd0;
            ex_code_q          <= 5'd0;
            rf_we_q            <= 1'b0;
            bypass_rdc_valid_q <= 1'b0;
            cp0_rd_mux_sel_q   <= 1'b0;
            cp0_we_q           <= 1'b0;
            ex_q               <= 1'b0;
            eret_q             <= 1'b0;
            bd_q               <= 1'b0;
        end else if (wb_allowin) begin
            wb_valid <= mem_wb_validto;
            if (mem_wb_validto) begin
                wb_result_q        <= wb_result_in;
                cp0_data_q         <= cp0_data_in;
                pc_q               <= pc_in;
                rdc_q              <= rdc_mem_in;
                cp0_rdc_q          <= cp0_rdc_in;
                ex_code_q          <= ex_code_in;
                rf_we_q            <= rf_we_in;
                bypass_rdc_valid_q <= bypass_rdc_valid_in;
                cp0_rd_mux_sel_q   <= cp0_rd_mux_sel_in;
                cp0_we_q           <= cp0_we_in;
                ex_q               <= ex_wb_in;
                eret_q             <= eret_flush_in;
                bd_q               <= branch_delay_wb_in;
            end
        end
    end

    // Interrupts win over a carried exception and report ExcCode 0
    assign int_pend    = (|(int_sig & int_mask)) & ie & ~exl;
    assign take        = wb_valid & (ex_q | int_pend);
    assign take_code   = int_pend ? 5'd0 : ex_code_q;
    assign mtc0_commit = wb_valid & cp0_we_q & ~take & ~eret_q;

    assign ex           = take;
    assign flush        = wb_valid & (take | eret_q);
    assign rf_we        = wb_valid & rf_we_q & ~take;
    assign wb_rdc_valid = wb_valid & bypass_rdc_valid_q & rf_we_q & ~take;
    assign rdc_wb       = rdc_q;
    assign wb_result    = cp0_rd_mux_sel_q ? cp0_rdata : wb_result_q;
    assign bypass_wb    = wb_result;

`ifdef CP0_TIMER_EN
    logic [31:0] count, compare;
    logic        tick, timer_ip;

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 32'd0;
            compare  <= 32'd0;
            tick     <= 1'b0;
            timer_ip <= 1'b0;
        end else begin
            tick <= ~tick;
            if (mtc0_commit && cp0_rdc_q == 5'd9)
                count <= cp0_data_q;
            else if (tick)
                count <= count + 32'd1;
            if (mtc0_commit && cp0_rdc_q == 5'd11) begin
                compare  <= cp0_data_q;
                timer_ip <= 1'b0;
            end else if (count == compare) begin
                timer_ip <= 1'b1;
            end
        end
    end

    assign ip7_src = timer_ip;
`else
    assign ip7_src = int_sig_in[7];
`endif

    assign status_rd = {16'd0, int_mask, 6'd0, exl, ie};
    assign cause_rd  = {cause_bd, 15'd0, int_sig, 1'b0, cause_exc, 2'b00};

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_rdc_q)
            5'd12:   cp0_rdata = status_rd;
            5'd13:   cp0_rdata = cause_rd;
            5'd14:   cp0_rdata = epc_out;
`ifdef CP0_TIMER_EN
            5'd9:    cp0_rdata = count;
            5'd11:   cp0_rdata = compare;
`endif
            default: cp0_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hlt       <= 1'b0;
            ie        <= STATUS_RST[0];
            exl       <= STATUS_RST[1];
            int_mask  <= STATUS_RST[15:8];
            int_sig   <= 8'd0;
            cause_bd  <= 1'b0;
            cause_exc <= 5'd0;
            epc_out   <= 32'd0;
        end else begin
            int_sig[7:2] <= {ip7_src, int_sig_in[6:2]};
            if (take) begin
                exl       <= 1'b1;
                epc_out   <= bd_q ? pc_q - 32'd4 : pc_q;
                cause_bd  <= bd_q;
                cause_exc <= take_code;
                if (!int_pend && take_code == HALT_CODE)
                    hlt <= 1'b1;
            end else if (wb_valid && eret_q) begin
                exl <= 1'b0;
            end else if (mtc0_commit) begin
                case (cp0_rdc_q)
                    5'd12: begin
                        ie       <= cp0_data_q[0];
                        exl      <= cp0_data_q[1];
                        int_mask <= cp0_data_q[15:8];
                    end
                    5'd13:   int_sig[1:0] <= cp0_data_q[9:8];
                    5'd14:   epc_out <= cp0_data_q;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_wb_cp0.sv
// tb/tb_pipe_wb_cp0.sv - directed self-checking bench for pipe_wb_cp0
module tb_pipe_wb_cp0;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wb_validto, bypass_rdc_valid_in, rf_we_in;
    logic [31:0] wb_result_in, cp0_data_in, pc_in;
    logic [4:0]  rdc_mem_in, cp0_rdc_in, ex_code_in;
    logic        cp0_rd_mux_sel_in, cp0_we_in, ex_wb_in, eret_flush_in, branch_delay_wb_in;
    logic [7:0]  int_sig_in;
    logic        wb_allowin, rf_we, wb_rdc_valid, ex, flush, hlt, ie, exl;
    logic [4:0]  rdc_wb;
    logic [31:0] wb_result, bypass_wb, epc_out;
    logic [7:0]  int_mask, int_sig;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_wb_cp0 dut (
        .clk(clk), .rst(rst),
        .mem_wb_validto(mem_wb_validto), .bypass_rdc_valid_in(bypass_rdc_valid_in),
        .wb_result_in(wb_result_in), .rdc_mem_in(rdc_mem_in), .rf_we_in(rf_we_in),
        .cp0_rd_mux_sel_in(cp0_rd_mux_sel_in), .cp0_we_in(cp0_we_in),
        .cp0_rdc_in(cp0_rdc_in), .cp0_data_in(cp0_data_in),
        .ex_wb_in(ex_wb_in), .ex_code_in(ex_code_in), .eret_flush_in(eret_flush_in),
        .branch_delay_wb_in(branch_delay_wb_in), .pc_in(pc_in), .int_sig_in(int_sig_in),
        .wb_allowin(wb_allowin), .rdc_wb(rdc_wb), .wb_result(wb_result), .rf_we(rf_we),
        .bypass_wb(bypass_wb), .wb_rdc_valid(wb_rdc_valid), .ex(ex), .flush(flush),
        .hlt(hlt), .ie(ie), .exl(exl), .int_mask(int_mask), .int_sig(int_sig),
        .epc_out(epc_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        mem_wb_validto = 0; bypass_rdc_valid_in = 0; rf_we_in = 0;
        wb_result_in = 0; rdc_mem_in = 0; cp0_rd_mux_sel_in = 0; cp0_we_in = 0;
        cp0_rdc_in = 0; cp0_data_in = 0; ex_wb_in = 0; ex_code_in = 0;
        eret_flush_in = 0; branch_delay_wb_in = 0; pc_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; int_sig_in = 8'h00; idle();
        tick(); tick();
        rst = 0;
        check("rst_allowin", wb_allowin, 1);
        check("rst_rf_we", rf_we, 0);
        check("rst_result", wb_result, 0);
        check("rst_ex", ex, 0);
        check("rst_flush", flush, 0);
        check("rst_hlt", hlt, 0);
        check("rst_status", {ie, exl, int_mask}, 0);
        check("rst_epc", epc_out, 0);
        check("rst_ip", int_sig, 0);

        // plain ALU retire
        mem_wb_validto = 1; rf_we_in = 1; bypass_rdc_valid_in = 1;
        rdc_mem_in = 5'd3; wb_result_in = 32'h1234;
        tick();
        check("alu_rf_we", rf_we, 1);
        check("alu_rdc", rdc_wb, 3);
        check("alu_result", wb_result, 32'h1234);
        check("alu_bypass", bypass_wb, 32'h1234);
        check("alu_fwd_valid", wb_rdc_valid, 1);
        check("alu_ex", ex, 0);

        // exception in a delay slot
        idle(); mem_wb_validto = 1; rf_we_in = 1; bypass_rdc_valid_in = 1;
        ex_wb_in = 1; ex_code_in = 5'd8; pc_in = 32'h0040_0010; branch_delay_wb_in = 1;
        tick();
        check("exc_ex", ex, 1);
        check("exc_flush", flush, 1);
        check("exc_rf_we", rf_we, 0);
        check("exc_fwd_valid", wb_rdc_valid, 0);
        idle(); mem_wb_validto = 1; cp0_rd_mux_sel_in = 1; cp0_rdc_in = 5'd13;
        tick();
        check("exc_epc", epc_out, 32'h0040_000C);
        check("exc_exl", exl, 1);
        check("exc_cause", wb_result, 32'h8000_0020);
        check("exc_mfc0_no_ex", ex, 0);

        // eret
        idle(); mem_wb_validto = 1; eret_flush_in = 1;
        tick();
        check("eret_flush", flush, 1);
        check("eret_ex", ex, 0);
        idle();
        tick();
        check("eret_exl", exl, 0);
        check("eret_epc", epc_out, 32'h0040_000C);

        // enable IE and IM[2]
        idle(); mem_wb_validto = 1; cp0_we_in = 1; cp0_rdc_in = 5'd12; cp0_data_in = 32'h0000_0401;
        tick();
        check("mtc0_ex", ex, 0);
        idle();
        tick();
        check("mtc0_ie", ie, 1);
        check("mtc0_im", int_mask, 8'h04);
        check("mtc0_exl", exl, 0);

        // hardware interrupt on line 2
        int_sig_in = 8'h04;
        tick();
        check("int_ip", int_sig, 8'h04);
        check("int_idle_no_ex", ex, 0);
        mem_wb_validto = 1; pc_in = 32'h100; rf_we_in = 1; rdc_mem_in = 5'd7;
        tick();
        check("int_ex", ex, 1);
        check("int_flush", flush, 1);
        check("int_rf_we", rf_we, 0);
        idle(); mem_wb_validto = 1; cp0_rd_mux_sel_in = 1; cp0_rdc_in = 5'd13;
        tick();
        check("int_epc", epc_out, 32'h100);
        check("int_exl", exl, 1);
        check("int_cause", wb_result, 32'h0000_0400);
        check("int_masked_by_exl", ex, 0);

        // unimplemented CP0 reg reads zero, STATUS read-back
        idle(); mem_wb_validto = 1; cp0_rd_mux_sel_in = 1; cp0_rdc_in = 5'd9;
        tick();
        check("mfc0_unimpl", wb_result, 0);
        idle(); mem_wb_validto = 1; cp0_rd_mux_sel_in = 1; cp0_rdc_in = 5'd12;
        tick();
        check("mfc0_status", wb_result, 32'h0000_0403);

        // leave exception level
        int_sig_in = 8'h00;
        idle(); mem_wb_validto = 1; eret_flush_in = 1;
        tick();
        idle();
        tick();
        check("eret2_exl", exl, 0);
        check("eret2_ip", int_sig, 8'h00);

        // breakpoint halts
        idle(); mem_wb_validto = 1; ex_wb_in = 1; ex_code_in = 5'd9; pc_in = 32'h200;
        tick();
        check("bp_ex", ex, 1);
        check("bp_hlt_pre", hlt, 0);
        idle();
        tick();
        check("bp_hlt", hlt, 1);
        check("bp_allowin", wb_allowin, 0);
        check("bp_epc", epc_out, 32'h200);
        mem_wb_validto = 1; rf_we_in = 1; rdc_mem_in = 5'd9; wb_result_in = 32'hDEAD;
        tick();
        check("bp_hlt_sticky", hlt, 1);
        check("bp_frozen_rf_we", rf_we, 0);
        idle();
        rst = 1;
        tick();
        rst = 0;
        check("rst2_hlt", hlt, 0);
        check("rst2_allowin", wb_allowin, 1);
        check("rst2_exl", exl, 0);

        // software IP[1:0] via CAUSE write
        idle(); mem_wb_validto = 1; cp0_we_in = 1; cp0_rdc_in = 5'd13; cp0_data_in = 32'h0000_FF03;
        tick();
        idle();
        tick();
        check("sw_ip", int_sig, 8'h03);
        check("sw_ip_no_ex", ex, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
